// File: rtl/nbuf_pkg.sv
// Shared types and helpers for the N-way buffer rotation controller.
package nbuf_pkg;

  // Ownership state of one SRAM buffer.
  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_e;

  localparam int MODE_LATEST   = 0;  // overflow reclaims the oldest READY buffer
  localparam int MODE_LOSSLESS = 1;  // overflow stalls the producer

  localparam int MAX_BUFS = 16;
  localparam int MAX_SEL  = 4;

  // One-hot decode of a buffer index; all-zero when the owner is absent.
  function automatic logic [MAX_BUFS-1:0] idx_to_onehot(input logic [MAX_SEL-1:0] idx,
                                                        input logic              en);
    logic [MAX_BUFS-1:0] oh;
    oh = '0;
    if (en) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/nbuf_control_if.sv
// Producer/consumer side of the buffer rotation controller: triggers in,
// buffer selects and status out.
interface nbuf_control_if #(
  parameter int NUM_BUFS = 3,
  parameter int SEL_W    = $clog2(NUM_BUFS),
  parameter int CNT_W    = 16
);
  logic                capture_trigger;
  logic                transmission_trigger;
  logic [SEL_W-1:0]    wr_sel;
  logic [NUM_BUFS-1:0] wr_onehot;
  logic                wr_valid;
  logic [SEL_W-1:0]    rd_sel;
  logic [NUM_BUFS-1:0] rd_onehot;
  logic                rd_valid;
  logic [SEL_W:0]      ready_count;
  logic [CNT_W-1:0]    loss_count;

  // Capture/transmit datapath side: raises triggers, consumes selects.
  modport master (
    output capture_trigger, transmission_trigger,
    input  wr_sel, wr_onehot, wr_valid, rd_sel, rd_onehot, rd_valid,
    input  ready_count, loss_count
  );

  // Controller side.
  modport slave (
    input  capture_trigger, transmission_trigger,
    output wr_sel, wr_onehot, wr_valid, rd_sel, rd_onehot, rd_valid,
    output ready_count, loss_count
  );
endinterface

// File: rtl/nbuf_index_fifo.sv
// Circular queue of buffer indices in completion order. Push and pop may
// happen in the same cycle; the caller never pushes when full or pops when
// empty.
module nbuf_index_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_ptr;
  logic [W-1:0] wr_ptr;

  function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
    return (p == W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage.
  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/nbuf_control.sv
// N-way buffer rotation controller: tracks FREE/WRITING/READY/READING
// ownership of NUM_BUFS buffers between one producer and one consumer.
module nbuf_control
  import nbuf_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int SEL_W    = $clog2(NUM_BUFS),
  parameter int MODE     = MODE_LATEST,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  nbuf_control_if.slave bus
);

  buf_state_e          st_q [NUM_BUFS];
  buf_state_e          st_n [NUM_BUFS];
  logic [SEL_W-1:0]    wr_sel_q, wr_sel_n;
  logic [SEL_W-1:0]    rd_sel_q, rd_sel_n;
  logic                wr_valid_q, wr_valid_n;
  logic                rd_valid_q, rd_valid_n;
  logic [NUM_BUFS-1:0] wr_oh_q, rd_oh_q;
  logic [CNT_W-1:0]    loss_q, loss_n;
  logic                cap_q, tx_q;
  logic                cap_edge, tx_edge;
  logic                free_found;
  logic [SEL_W-1:0]    free_idx;
  logic                q_push, q_pop, q_empty;
  logic [SEL_W-1:0]    q_head;
  logic [SEL_W:0]      q_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cap_edge = bus.capture_trigger & ~cap_q;
  assign tx_edge  = bus.transmission_trigger & ~tx_q;

  // Lowest-index FREE buffer, counting one released by this cycle's transmission edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (st_q[i] == BUF_FREE || (tx_edge && rd_valid_q && rd_sel_q == SEL_W'(i))) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  // Ordered event processing: release, capture, consumer refill, producer refill.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    st_n       = st_q;
    wr_sel_n   = wr_sel_q;
    wr_valid_n = wr_valid_q;
    rd_sel_n   = rd_sel_q;
    rd_valid_n = rd_valid_q;
    loss_n     = loss_q;
    q_push     = 1'b0;
    q_pop      = 1'b0;

    if (tx_edge && rd_valid_q) begin
      st_n[rd_sel_q] = BUF_FREE;
      rd_valid_n     = 1'b0;
    end

    if (cap_edge) begin
      if (wr_valid_q) begin
        st_n[wr_sel_q] = BUF_READY;
        q_push         = 1'b1;
        if (free_found) begin
          st_n[free_idx] = BUF_WRITING;
          wr_sel_n       = free_idx;
        end else if (MODE == MODE_LATEST) begin
          // Queue holds at least two entries here, so the head is never the
          // buffer just completed.
          q_pop        = 1'b1;
          st_n[q_head] = BUF_WRITING;
          wr_sel_n     = q_head;
          loss_n       = sat_inc(loss_q);
        end else begin
          wr_valid_n = 1'b0;
        end
      end else begin
        loss_n = sat_inc(loss_q);
      end
    end

    if (!rd_valid_n && (q_push || !q_empty)) begin
      if (q_empty) begin
        // Hand the just-completed buffer straight to the consumer.
        rd_sel_n = wr_sel_q;
        q_push   = 1'b0;
      end else begin
        rd_sel_n = q_head;
        q_pop    = 1'b1;
      end
      st_n[rd_sel_n] = BUF_READING;
      rd_valid_n     = 1'b1;
    end

    if (MODE == MODE_LOSSLESS && !wr_valid_n && free_found) begin
      st_n[free_idx] = BUF_WRITING;
      wr_sel_n       = free_idx;
      wr_valid_n     = 1'b1;
    end
  end

  nbuf_index_fifo #(
    .DEPTH (NUM_BUFS),
    .W     (SEL_W)
  ) u_ready_q (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (wr_sel_q),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  // Ownership state, trigger history and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values of the same clock edge, independent of statement order.
    if (reset) begin
      for (int i = 0; i < NUM_BUFS; i++) st_q[i] <= (i == 0) ? BUF_WRITING : BUF_FREE;
      wr_sel_q   <= '0;
      wr_valid_q <= 1'b1;
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_oh_q    <= NUM_BUFS'(1);
      rd_oh_q    <= '0;
      loss_q     <= '0;
      cap_q      <= 1'b1;
      tx_q       <= 1'b1;
    end else begin
      st_q       <= st_n;
      wr_sel_q   <= wr_sel_n;
      wr_valid_q <= wr_valid_n;
      rd_sel_q   <= rd_sel_n;
      rd_valid_q <= rd_valid_n;
      wr_oh_q    <= NUM_BUFS'(idx_to_onehot(MAX_SEL'(wr_sel_n), wr_valid_n));
      rd_oh_q    <= NUM_BUFS'(idx_to_onehot(MAX_SEL'(rd_sel_n), rd_valid_n));
      loss_q     <= loss_n;
      cap_q      <= bus.capture_trigger;
      tx_q       <= bus.transmission_trigger;
    end
  end

  assign bus.wr_sel      = wr_sel_q;
  assign bus.wr_onehot   = wr_oh_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.rd_sel      = rd_sel_q;
  assign bus.rd_onehot   = rd_oh_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.ready_count = q_count;
  assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_nbuf_control.sv
// Bench for nbuf_control: seven configurations run in lockstep against a
// queue-based ownership model; expectations are queued per cycle and a
// separate monitor compares them with the DUT outputs.
module tb_nbuf_control;

  localparam int NCFG = 7;

  function automatic int nb_of(input int g);
    case (g)
      0: return 3;
      1: return 4;
      2: return 3;
      3: return 5;
      4: return 5;
      5: return 16;
      default: return 16;
    endcase
  endfunction

  function automatic int md_of(input int g);
    case (g)
      0, 3, 5: return nbuf_pkg::MODE_LATEST;
      default: return nbuf_pkg::MODE_LOSSLESS;
    endcase
  endfunction

  typedef struct {
    int wr_sel;
    int wr_oh;
    bit wr_valid;
    int rd_sel;
    int rd_oh;
    bit rd_valid;
    int rcount;
    int loss;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [NCFG];
  logic cap [NCFG];
  logic tx  [NCFG];

  int a_wr_sel [NCFG];
  int a_wr_oh  [NCFG];
  int a_wr_v   [NCFG];
  int a_rd_sel [NCFG];
  int a_rd_oh  [NCFG];
  int a_rd_v   [NCFG];
  int a_rcount [NCFG];
  int a_loss   [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NB = nb_of(g);
    localparam int MD = md_of(g);

    nbuf_control_if #(.NUM_BUFS(NB), .CNT_W(16)) bus ();

    nbuf_control #(.NUM_BUFS(NB), .MODE(MD), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus)
    );

    assign bus.capture_trigger      = cap[g];
    assign bus.transmission_trigger = tx[g];
    assign a_wr_sel[g] = int'(bus.wr_sel);
    assign a_wr_oh[g]  = int'(bus.wr_onehot);
    assign a_wr_v[g]   = int'(bus.wr_valid);
    assign a_rd_sel[g] = int'(bus.rd_sel);
    assign a_rd_oh[g]  = int'(bus.rd_onehot);
    assign a_rd_v[g]   = int'(bus.rd_valid);
    assign a_rcount[g] = int'(bus.ready_count);
    assign a_loss[g]   = int'(bus.loss_count);
  end

  // Reference model: who owns which buffer, plus the READY queue in completion order.
  int    m_wr      [NCFG];   // producer's buffer, -1 when stalled
  int    m_rd      [NCFG];   // consumer's buffer, -1 when idle
  int    m_last_rd [NCFG];
  int    m_loss    [NCFG];
  bit    m_pc      [NCFG];
  bit    m_pt      [NCFG];
  int    m_q       [NCFG][$];
  snap_t expq      [NCFG][$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int lowest_free(input int g);
    for (int b = 0; b < nb_of(g); b++) begin
      bit owned;
      owned = (b == m_wr[g]) || (b == m_rd[g]);
      for (int k = 0; k < m_q[g].size(); k++) if (m_q[g][k] == b) owned = 1'b1;
      if (!owned) return b;
    end
    return -1;
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void model_step(input int g, input bit r, input bit c, input bit t);
    bit ce, te;
    if (r) begin
      m_wr[g] = 0; m_rd[g] = -1; m_last_rd[g] = 0; m_loss[g] = 0;
      m_pc[g] = 1'b1; m_pt[g] = 1'b1;
      m_q[g].delete();
      return;
    end
    ce = c && !m_pc[g];
    te = t && !m_pt[g];
    m_pc[g] = c;
    m_pt[g] = t;
    if (te && m_rd[g] >= 0) m_rd[g] = -1;
    if (ce) begin
      if (m_wr[g] >= 0) begin
        m_q[g].push_back(m_wr[g]);
        m_wr[g] = -1;
        m_wr[g] = lowest_free(g);
        if (m_wr[g] < 0 && md_of(g) == nbuf_pkg::MODE_LATEST) begin
          m_wr[g]   = m_q[g].pop_front();
          m_loss[g] = sat16(m_loss[g]);
        end
      end else begin
        m_loss[g] = sat16(m_loss[g]);
      end
    end
    if (m_rd[g] < 0 && m_q[g].size() > 0) begin
      m_rd[g]      = m_q[g].pop_front();
      m_last_rd[g] = m_rd[g];
    end
    if (m_wr[g] < 0) m_wr[g] = lowest_free(g);
  endfunction

  function automatic snap_t model_snap(input int g);
    snap_t s;
    s.wr_valid = (m_wr[g] >= 0);
    s.wr_sel   = s.wr_valid ? m_wr[g] : 0;
    s.wr_oh    = s.wr_valid ? (1 << m_wr[g]) : 0;
    s.rd_valid = (m_rd[g] >= 0);
    s.rd_sel   = m_last_rd[g];
    s.rd_oh    = s.rd_valid ? (1 << m_rd[g]) : 0;
    s.rcount   = m_q[g].size();
    s.loss     = m_loss[g];
    return s;
  endfunction

  // Inputs change #1 after the falling edge, away from the sampling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int g, input bit r, input bit c, input bit t);
    rst[g] = r;
    cap[g] = c;
    tx[g]  = t;
    model_step(g, r, c, t);
    expq[g].push_back(model_snap(g));
  endtask

  task automatic all_cfg(input bit r, input bit c, input bit t);
    tick();
    for (int g = 0; g < NCFG; g++) drive_cfg(g, r, c, t);
  endtask

  task automatic random_phase(input int cycles, input int tx_pct);
    for (int i = 0; i < cycles; i++) begin
      tick();
      for (int g = 0; g < NCFG; g++)
        drive_cfg(g, $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < tx_pct);
    end
  endtask

  // Monitor: one expected snapshot per configuration per cycle, plus the
  // producer/consumer disjointness rule.
  initial begin
    snap_t e, a;
    int    cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < NCFG; g++) begin
        if (expq[g].size() > 0) begin
          e = expq[g].pop_front();
          a.wr_sel   = a_wr_sel[g];
          a.wr_oh    = a_wr_oh[g];
          a.wr_valid = a_wr_v[g] != 0;
          a.rd_sel   = a_rd_sel[g];
          a.rd_oh    = a_rd_oh[g];
          a.rd_valid = a_rd_v[g] != 0;
          a.rcount   = a_rcount[g];
          a.loss     = a_loss[g];
          n_checks++;
          if (a.wr_valid != e.wr_valid || (e.wr_valid && a.wr_sel != e.wr_sel) ||
              a.wr_oh != e.wr_oh || a.rd_valid != e.rd_valid || a.rd_sel != e.rd_sel ||
              a.rd_oh != e.rd_oh || a.rcount != e.rcount || a.loss != e.loss) begin
            n_fail++;
            $display("FAIL outputs cfg%0d (nb=%0d mode=%0d) cycle %0d: got wr=%0d/v%0b/oh%h rd=%0d/v%0b/oh%h ready=%0d loss=%0d, expected wr=%0d/v%0b/oh%h rd=%0d/v%0b/oh%h ready=%0d loss=%0d",
                     g, nb_of(g), md_of(g), cyc,
                     a.wr_sel, a.wr_valid, a.wr_oh, a.rd_sel, a.rd_valid, a.rd_oh, a.rcount, a.loss,
                     e.wr_sel, e.wr_valid, e.wr_oh, e.rd_sel, e.rd_valid, e.rd_oh, e.rcount, e.loss);
          end
          if (a.wr_valid && a.rd_valid) begin
            n_checks++;
            if (a.wr_sel == a.rd_sel) begin
              n_fail++;
              $display("FAIL sel_clash cfg%0d cycle %0d: wr_sel=%0d rd_sel=%0d, expected distinct",
                       g, cyc, a.wr_sel, a.rd_sel);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios on every configuration, then random streams.
  initial begin
    for (int g = 0; g < NCFG; g++) begin
      rst[g] = 1'b1; cap[g] = 1'b0; tx[g] = 1'b0;
      m_wr[g] = 0; m_rd[g] = -1; m_last_rd[g] = 0; m_loss[g] = 0;
      m_pc[g] = 1'b1; m_pt[g] = 1'b1;
    end

    all_cfg(1, 0, 0);
    all_cfg(1, 0, 0);
    all_cfg(0, 0, 0);

    // Captures with no transmission: fill, then reclaim (latest) or stall (lossless).
    for (int i = 0; i < 18; i++) begin
      all_cfg(0, 1, 0);
      all_cfg(0, 0, 0);
    end
    // One transmission frees the consumer's buffer for the stalled producer.
    all_cfg(0, 0, 1);
    all_cfg(0, 0, 0);
    // Drain everything.
    for (int i = 0; i < 18; i++) begin
      all_cfg(0, 0, 1);
      all_cfg(0, 0, 0);
    end

    // Both triggers held high through reset release: nothing may fire.
    all_cfg(0, 1, 1);
    all_cfg(1, 1, 1);
    all_cfg(1, 1, 1);
    all_cfg(0, 1, 1);
    all_cfg(0, 1, 1);
    all_cfg(0, 0, 0);
    // First capture after reset, then simultaneous edges with the queue empty.
    all_cfg(0, 1, 0);
    all_cfg(0, 0, 0);
    all_cfg(0, 1, 1);
    all_cfg(0, 0, 0);

    // Random streams: slow consumer first to force overflow, then balanced.
    random_phase(250, 15);
    random_phase(250, 50);

    all_cfg(0, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
